// File: rtl/wb_trace_buffer_if.sv
// rtl/wb_trace_buffer_if.sv - writeback capture and pop-readout bus for wb_trace_buffer
// rd_ts_o exists only when WB_TRACE_TIMESTAMP_EN is defined.
interface wb_trace_buffer_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          wb_we_i;
    logic [AW-1:0] wb_wd_i;
    logic [DW-1:0] wb_wdata_i;
    logic          rd_en_i;
    logic          rd_valid_o;
    logic [AW-1:0] rd_wd_o;
    logic [DW-1:0] rd_data_o;
`ifdef WB_TRACE_TIMESTAMP_EN
    logic [31:0]   rd_ts_o;
`endif

    modport master (
        output wb_we_i, wb_wd_i, wb_wdata_i, rd_en_i,
`ifdef WB_TRACE_TIMESTAMP_EN
        input  rd_ts_o,
`endif
        input  rd_valid_o, rd_wd_o, rd_data_o
    );

    modport slave (
        input  wb_we_i, wb_wd_i, wb_wdata_i, rd_en_i,
`ifdef WB_TRACE_TIMESTAMP_EN
        output rd_ts_o,
`endif
        output rd_valid_o, rd_wd_o, rd_data_o
    );
endinterface

// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - DEPTH-entry FIFO of retired register writebacks with last-write latch
// Optional per-entry cycle timestamps are enabled by WB_TRACE_TIMESTAMP_EN.
module wb_trace_buffer #(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int DEPTH     = 16,
    parameter int WRAP      = 0,
    parameter int FILTER_X0 = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     cap_en_i,
    wb_trace_buffer_if.slave         bus,
    output logic [AW-1:0]            last_wd_o,
    output logic [DW-1:0]            last_wdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     overflow_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
`ifdef WB_TRACE_TIMESTAMP_EN
    localparam int EW = 32 + AW + DW;
`else
    localparam int EW = AW + DW;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;
    logic          mem_we;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          rd_valid_q, rd_valid_d;
    logic [AW-1:0] rd_wd_q, rd_wd_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic [AW-1:0] last_wd_q, last_wd_d;
    logic [DW-1:0] last_wdata_q, last_wdata_d;
`ifdef WB_TRACE_TIMESTAMP_EN
    logic [31:0]   ts_q, ts_d;
    logic [31:0]   rd_ts_q, rd_ts_d;
`endif

    logic acc, pop, empty, full;

    always_comb begin
        acc   = bus.wb_we_i & cap_en_i & ~((FILTER_X0 != 0) & (bus.wb_wd_i == '0));
        empty = (count_q == '0);
        full  = (count_q == CW'(DEPTH));
        pop   = bus.rd_en_i & ~empty;
    end

`ifdef WB_TRACE_TIMESTAMP_EN
    assign wr_entry = {ts_q, bus.wb_wd_i, bus.wb_wdata_i};
`else
    assign wr_entry = {bus.wb_wd_i, bus.wb_wdata_i};
`endif
    assign rd_entry = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        rd_valid_d   = 1'b0;
        rd_wd_d      = rd_wd_q;
        rd_data_d    = rd_data_q;
        last_wd_d    = last_wd_q;
        last_wdata_d = last_wdata_q;
        mem_we       = 1'b0;
`ifdef WB_TRACE_TIMESTAMP_EN
        ts_d         = ts_q + 32'd1;
        rd_ts_d      = rd_ts_q;
`endif
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
`ifdef WB_TRACE_TIMESTAMP_EN
            ts_d     = '0;
`endif
        end else begin
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + PW'(1);
                rd_valid_d = 1'b1;
                rd_wd_d    = rd_entry[DW +: AW];
                rd_data_d  = rd_entry[DW-1:0];
`ifdef WB_TRACE_TIMESTAMP_EN
                rd_ts_d    = rd_entry[EW-1 -: 32];
`endif
            end
            if (acc) begin
                last_wd_d    = bus.wb_wd_i;
                last_wdata_d = bus.wb_wdata_i;
                // A simultaneous pop frees the slot, so a full buffer never drops in that case
                if (!full || pop) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end else begin
                    ovf_d = 1'b1;
                    if (WRAP != 0) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        rd_ptr_d = rd_ptr_q + PW'(1);
                    end
                end
            end
            if (mem_we && !pop && !full) begin
                count_d = count_q + CW'(1);
            end else if (pop && !mem_we) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_wd_q      <= '0;
            rd_data_q    <= '0;
            last_wd_q    <= '0;
            last_wdata_q <= '0;
`ifdef WB_TRACE_TIMESTAMP_EN
            ts_q         <= '0;
            rd_ts_q      <= '0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            rd_valid_q   <= rd_valid_d;
            rd_wd_q      <= rd_wd_d;
            rd_data_q    <= rd_data_d;
            last_wd_q    <= last_wd_d;
            last_wdata_q <= last_wdata_d;
`ifdef WB_TRACE_TIMESTAMP_EN
            ts_q         <= ts_d;
            rd_ts_q      <= rd_ts_d;
`endif
        end
    end

    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_wd_o    = rd_wd_q;
    assign bus.rd_data_o  = rd_data_q;
`ifdef WB_TRACE_TIMESTAMP_EN
    assign bus.rd_ts_o    = rd_ts_q;
`endif
    assign last_wd_o      = last_wd_q;
    assign last_wdata_o   = last_wdata_q;
    assign count_o        = count_q;
    assign empty_o        = empty;
    assign full_o         = full;
    assign overflow_o     = ovf_q;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb/tb_wb_trace_buffer.sv - drop-mode and wrap-mode trace buffers run side by side against a queue model
module tb_wb_trace_buffer;
    localparam int DEPTH = 16;

    typedef struct {
        logic [4:0]  wd;
        logic [31:0] data;
        logic [31:0] ts;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        cap_en = 1'b0;
    logic        we = 1'b0;
    logic        rd_en = 1'b0;
    logic [4:0]  wd = '0;
    logic [31:0] wdata = '0;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [4:0]  last_wd    [2];
    logic [31:0] last_wdata [2];
    logic [4:0]  count      [2];
    logic        empty      [2];
    logic        full       [2];
    logic        ovf        [2];

    ent_t        mq [2][$];
    logic        m_rdv    [2];
    logic [4:0]  m_rdwd   [2];
    logic [31:0] m_rddata [2];
    logic [31:0] m_rdts   [2];
    logic [4:0]  m_lwd    [2];
    logic [31:0] m_lwdata [2];
    logic        m_ovf    [2];
    logic [31:0] ts_m;

    wb_trace_buffer_if #(.DW(32), .AW(5)) bus0 ();
    wb_trace_buffer_if #(.DW(32), .AW(5)) bus1 ();

    assign bus0.wb_we_i = we;  assign bus0.wb_wd_i = wd;  assign bus0.wb_wdata_i = wdata;  assign bus0.rd_en_i = rd_en;
    assign bus1.wb_we_i = we;  assign bus1.wb_wd_i = wd;  assign bus1.wb_wdata_i = wdata;  assign bus1.rd_en_i = rd_en;

    wb_trace_buffer #(.DW(32), .AW(5), .DEPTH(DEPTH), .WRAP(0), .FILTER_X0(1)) u_drop (
        .clk(clk), .rst(rst), .clear_i(clear), .cap_en_i(cap_en), .bus(bus0),
        .last_wd_o(last_wd[0]), .last_wdata_o(last_wdata[0]), .count_o(count[0]),
        .empty_o(empty[0]), .full_o(full[0]), .overflow_o(ovf[0])
    );

    wb_trace_buffer #(.DW(32), .AW(5), .DEPTH(DEPTH), .WRAP(1), .FILTER_X0(1)) u_wrap (
        .clk(clk), .rst(rst), .clear_i(clear), .cap_en_i(cap_en), .bus(bus1),
        .last_wd_o(last_wd[1]), .last_wdata_o(last_wdata[1]), .count_o(count[1]),
        .empty_o(empty[1]), .full_o(full[1]), .overflow_o(ovf[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            m_rdv[k] = 1'b0; m_rdwd[k] = '0; m_rddata[k] = '0; m_rdts[k] = '0;
            m_lwd[k] = '0; m_lwdata[k] = '0; m_ovf[k] = 1'b0;
        end
        ts_m = '0;
    endtask

    // One rising edge: pop the head, then append the new writeback following the buffer's policy
    task automatic model_edge();
        ent_t e;
        ent_t n;
        bit   acc, pop, was_full;
        n.wd = wd; n.data = wdata; n.ts = ts_m;
        acc = we && cap_en && (wd != 5'd0);
        for (int k = 0; k < 2; k++) begin
            if (clear) begin
                mq[k].delete();
                m_ovf[k] = 1'b0;
                m_rdv[k] = 1'b0;
            end else begin
                was_full = (mq[k].size() == DEPTH);
                pop      = rd_en && (mq[k].size() > 0);
                m_rdv[k] = pop;
                if (pop) begin
                    e = mq[k].pop_front();
                    m_rdwd[k] = e.wd; m_rddata[k] = e.data; m_rdts[k] = e.ts;
                end
                if (acc) begin
                    m_lwd[k] = wd; m_lwdata[k] = wdata;
                    if (!was_full || pop) begin
                        mq[k].push_back(n);
                    end else begin
                        m_ovf[k] = 1'b1;
                        if (k == 1) begin
                            void'(mq[k].pop_front());
                            mq[k].push_back(n);
                        end
                    end
                end
            end
        end
        ts_m = clear ? 32'd0 : ts_m + 32'd1;
    endtask

    task automatic cmp_dut(input int k, input logic rdv, input logic [4:0] rwd, input logic [31:0] rdata,
                           input logic [4:0] lwd, input logic [31:0] lwdata, input logic [4:0] cnt,
                           input logic emp, input logic ful, input logic ov);
        chk("rd_valid", k, rdv, m_rdv[k]);
        chk("rd_wd", k, rwd, m_rdwd[k]);
        chk("rd_data", k, rdata, m_rddata[k]);
        chk("last_wd", k, lwd, m_lwd[k]);
        chk("last_wdata", k, lwdata, m_lwdata[k]);
        chk("count", k, cnt, mq[k].size());
        chk("empty", k, emp, mq[k].size() == 0);
        chk("full", k, ful, mq[k].size() == DEPTH);
        chk("overflow", k, ov, m_ovf[k]);
    endtask

    task automatic compare_all();
        cmp_dut(0, bus0.rd_valid_o, bus0.rd_wd_o, bus0.rd_data_o, last_wd[0], last_wdata[0],
                count[0], empty[0], full[0], ovf[0]);
        cmp_dut(1, bus1.rd_valid_o, bus1.rd_wd_o, bus1.rd_data_o, last_wd[1], last_wdata[1],
                count[1], empty[1], full[1], ovf[1]);
`ifdef WB_TRACE_TIMESTAMP_EN
        chk("rd_ts", 0, bus0.rd_ts_o, m_rdts[0]);
        chk("rd_ts", 1, bus1.rd_ts_o, m_rdts[1]);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (bus0.rd_valid_o) pulses++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        cap_en = 1'b1;

        // three writebacks then four pops
        we = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wd = 5'(i); wdata = 32'(i * 32'h11);
            step();
        end
        we = 1'b0; rd_en = 1'b1; pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i < 3) begin
                chk("seq_wd", 0, bus0.rd_wd_o, i + 1);
                chk("seq_data", 0, bus0.rd_data_o, (i + 1) * 32'h11);
            end
        end
        rd_en = 1'b0;
        chk("pulses", 0, pulses, 3);
        chk("seq_count", 0, count[0], 0);
        chk("seq_last_wd", 0, last_wd[0], 3);
        chk("seq_last_wdata", 0, last_wdata[0], 32'h33);

        // x0 filter and capture disable
        we = 1'b1; wd = 5'd0; wdata = 32'hDEAD;
        step();
        chk("x0_count", 0, count[0], 0);
        chk("x0_last", 0, last_wdata[0], 32'h33);
        cap_en = 1'b0; wd = 5'd5; wdata = 32'h55;
        step();
        chk("capoff_count", 0, count[0], 0);
        chk("capoff_last", 0, last_wd[0], 3);
        cap_en = 1'b1;

        // 20 writes: drop mode keeps 1..16, wrap mode keeps 5..20
        for (int i = 1; i <= 20; i++) begin
            wd = 5'((i % 31) + 1); wdata = 32'(i);
            step();
            if (i == 17) begin
                chk("drop17_full", 0, full[0], 1);
                chk("drop17_ovf", 0, ovf[0], 1);
                chk("drop17_count", 0, count[0], 16);
            end
        end
        we = 1'b0;
        chk("wrap_ovf", 1, ovf[1], 1);
        chk("wrap_count", 1, count[1], 16);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("drop_pop", 0, bus0.rd_data_o, i + 1);
            chk("wrap_pop", 1, bus1.rd_data_o, i + 5);
        end
        rd_en = 1'b0;

        // clear, refill, then simultaneous push/pop while full
        clear = 1'b1;
        step();
        clear = 1'b0;
        we = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wd = 5'(i + 1); wdata = 32'h100 + 32'(i);
            step();
        end
        rd_en = 1'b1; wd = 5'd7; wdata = 32'h200;
        step();
        for (int k = 0; k < 2; k++) begin
            chk("fullrw_data", k, k == 0 ? bus0.rd_data_o : bus1.rd_data_o, 32'h100);
            chk("fullrw_count", k, count[k], 16);
            chk("fullrw_ovf", k, ovf[k], 0);
        end
        rd_en = 1'b0; clear = 1'b1; wdata = 32'h300;
        step();
        for (int k = 0; k < 2; k++) begin
            chk("clr_count", k, count[k], 0);
            chk("clr_empty", k, empty[k], 1);
            chk("clr_ovf", k, ovf[k], 0);
        end
        clear = 1'b0; we = 1'b0;

        // randomized traffic: fill-biased then drain-biased
        for (int i = 0; i < 400; i++) begin
            we     = 1'($urandom_range(0, 1));
            wd     = 5'($urandom_range(0, 31));
            wdata  = $urandom;
            cap_en = ($urandom_range(0, 7) != 0);
            rd_en  = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            clear  = ($urandom_range(0, 63) == 0);
            step();
        end
        clear = 1'b0; rd_en = 1'b0; cap_en = 1'b1;

        // asynchronous reset in the middle of a write burst
        we = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wd = 5'(i + 3); wdata = 32'hB000 + 32'(i);
            step();
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0; we = 1'b0;

        // writes at edges 10 and 13 after reset release
        for (int e = 0; e < 16; e++) begin
            we = (e == 10 || e == 13);
            wd = 5'(e); wdata = 32'hA000 + 32'(e);
            step();
        end
        we = 1'b0; rd_en = 1'b1;
        step();
        chk("ts_pop1_data", 0, bus0.rd_data_o, 32'hA00A);
`ifdef WB_TRACE_TIMESTAMP_EN
        chk("ts_pop1", 0, bus0.rd_ts_o, 10);
`endif
        step();
        chk("ts_pop2_data", 0, bus0.rd_data_o, 32'hA00D);
`ifdef WB_TRACE_TIMESTAMP_EN
        chk("ts_pop2", 0, bus0.rd_ts_o, 13);
`endif
        rd_en = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
